// File: rtl/booth_multiplier_seq.sv
// booth_multiplier_seq: sequential signed radix-2 Booth multiplier, one Booth step per clock
module booth_multiplier_seq #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH:0] a, m, a_sum, a_nx;
  logic [WIDTH-1:0] q, q_nx;
  logic q_1, q_1_nx;
  logic [CW-1:0] cnt;
  logic accept, last;
  assign accept = start && (state != CALC);
  assign last = (state == CALC) && (cnt == CW'(1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = (state == CALC) ? (last ? DONE : CALC) : (start ? CALC : IDLE);
  always_comb begin
    busy = (state == CALC);
    done = (state == DONE);
  end
  // A and M carry one extra sign bit so subtracting the most negative M cannot overflow
  always_comb begin
    a_sum = ({q[0], q_1} == 2'b01) ? a + m : ({q[0], q_1} == 2'b10) ? a - m : a;
    {a_nx, q_nx, q_1_nx} = {a_sum[WIDTH], a_sum, q};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a <= '0;
      m <= '0;
      q <= '0;
      q_1 <= 1'b0;
      cnt <= '0;
      product <= '0;
    end else if (accept) begin
      a <= '0;
      m <= {multiplicand[WIDTH-1], multiplicand};
      q <= multiplier;
      q_1 <= 1'b0;
      cnt <= CW'(WIDTH);
    end else if (state == CALC) begin
      a <= a_nx;
      q <= q_nx;
      q_1 <= q_1_nx;
      cnt <= cnt - 1'b1;
      if (last) product <= {a_nx[WIDTH-1:0], q_nx};
    end
endmodule
